// File: rtl/cardinal_nic.sv
// cardinal_nic: processor-side register interface bridging one router port.
// One-entry receive buffer (router -> processor) and one-entry transmit buffer
// (processor -> router), each with a full flag. Packets use big-endian bit
// numbering; bit 0 of the transmit packet is the virtual-channel bit and must
// match the router's polarity for the packet to leave.
module cardinal_nic #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  localparam logic [ADDR_W-1:0] A_IN_BUF     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_IN_STATUS  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OUT_BUF    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_OUT_STATUS = ADDR_W'(3);

  logic [0:DATA_W-1] in_buf;
  logic [0:DATA_W-1] out_buf;
  logic              in_full;
  logic              out_full;

  logic              load;
  logic              rd_in_buf;
  logic              rx_take;
  logic              store_take;
  logic              send;
  logic [0:DATA_W-1] load_data;

  // Access decode and handshake conditions, all from pre-edge state.
  always_comb begin
    load       = nicEn & ~nicWrEn;
    rd_in_buf  = load & (addr == A_IN_BUF);
    rx_take    = net_si & ~in_full;
    store_take = nicEn & nicWrEn & (addr == A_OUT_BUF) & ~out_full;
    send       = out_full & net_ro & (net_polarity == out_buf[0]);
    load_data  = '0;
    case (addr)
      A_IN_BUF:     load_data = in_buf;
      A_IN_STATUS:  load_data = DATA_W'(in_full);
      A_OUT_BUF:    load_data = '0;
      A_OUT_STATUS: load_data = DATA_W'(out_full);
      default:      load_data = '0;
    endcase
  end

  // Receive buffer: router fills when empty, a load of in_buf drains it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (rx_take) begin
      in_buf  <= net_di;
      in_full <= 1'b1;
    end else if (rd_in_buf) begin
      in_full <= 1'b0;
    end
  end

  // Transmit buffer: store fills when empty, a send empties it (data kept).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (send) begin
      out_full <= 1'b0;
    end else if (store_take) begin
      out_buf  <= d_in;
      out_full <= 1'b1;
    end
  end

  // Registered load data and one-cycle send strobe.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      d_out  <= '0;
      net_so <= 1'b0;
    end else begin
      net_so <= send;
      if (load) d_out <= load_data;
    end
  end

  // Router-facing views of buffer state; no path from processor inputs.
  always_comb begin
    net_ri = ~in_full;
    net_do = out_buf;
  end

endmodule
